instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//   Assembles instruction words for the MIPS control unit.
//   - Accepts one symbolic instruction per valid/ready handshake: op code, register numbers, immediate.
//   - Packs it into the 32-bit format that the control decoder consumes.
//   - Buffers packed words in a small FIFO and presents them on a valid/ready output.
//   - Sits between the program loader/test sequencer and instruction memory or the fetch path.
// PARAMETERS
//   DEPTH     4   output FIFO entries; power of two, >= 2
//   SHAMT_R   10  constant shamt field written into every R-type word
// PORTS
//   clk        in   1   single clock; all state updates on rising edge
//   rst_n      in   1   synchronous reset, active-low
//   in_valid   in   1   symbolic instruction present
//   in_ready   out  1   encoder can accept (FIFO not full)
//   in_op      in   3   0 LW, 1 SW, 2 ADD, 3 SUB, 4 MUL, 5 AND, 6 OR, 7 illegal
//   in_rs      in   5   base register (LW/SW) or first source register (R-type)
//   in_rt      in   5   load destination, store source, or second source register
//   in_rd      in   5   R-type destination; ignored for LW/SW
//   in_imm     in   16  LW/SW offset; ignored for R-type
//   out_valid  out  1   encoded word available at FIFO head
//   out_ready  in   1   consumer takes the word
//   out_instr  out  32  encoded instruction at FIFO head
//   err        out  1   one-cycle pulse: illegal op accepted and dropped
// BEHAVIOUR
//   Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
//   Reset values: FIFO empty; out_valid=0; out_instr=0; err=0; in_ready=1 in the first cycle after reset.
//   Handshakes:
//   - Input accepts when in_valid && in_ready.
//   - Output pops when out_valid && out_ready.
//   - out_instr is held stable while out_valid && !out_ready.
//   - in_ready = !full, registered. There is no same-cycle pass-through.
//   Latency: an accepted word is visible on out_instr/out_valid in the next cycle when the FIFO was empty.
//   Encoding (pure function, one cycle, registered into the FIFO):
//     LW  {6'd3, rs, rt, imm}       SW  {6'd4, rs, rt, imm}
//     R   {6'd2, rs, rt, rd, SHAMT_R[4:0], funct}
//         funct: ADD 6'h20, SUB 6'h22, MUL 6'h32, AND 6'h24, OR 6'h25
//   Illegal op (7): the handshake completes, nothing is written, err=1 for exactly the following cycle.
//   FIFO pointers: log2(DEPTH)+1 bits wide, wrap modulo 2*DEPTH.
//   - full: addresses equal, MSBs differ.
//   - empty: pointers equal.
//   Simultaneous push and pop:
//   - When not full and not empty: occupancy unchanged, order preserved.
//   - When empty: only the push occurs.
//   - When full: no push possible (in_ready=0); the pop frees one slot, and in_ready=1 the next cycle.
//   Reset mid-operation: all buffered words are discarded, out_valid drops in the same edge, and no err is generated.
// CONFIGURATION
//   Macro ENC_STATS_EN.
//   - Defined: adds output port instr_count [15:0], reset 0.
//     - Increments by 1 per output handshake and wraps 16'hFFFF -> 0.
//     - Illegal ops are not counted.
//   - Not defined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//   Shared package (mips_pkg):
//   - op enum values 0..7.
//   - opcode localparams OPC_R=2, OPC_LW=3, OPC_SW=4.
//   - funct localparams listed above; the control decoder uses the same constants.
//   Sub-module: instr_fifo (DEPTH, WIDTH=32), a synchronous FIFO with valid/ready on both sides.
//   Top level: encode logic, the err register, and the optional counter.
// TESTING
//   1 Reset, then LW rs=3 rt=0 imm=1 -> out_instr=32'h0C600001 one cycle later.
//     SW rs=1 rt=5 imm=10 -> 32'h1025000A.
//   2 R-type, one per op, in order:
//     ADD rs=5 rt=7 rd=3 -> 32'h08A71AA0;  SUB rs=4 rt=13 rd=10 -> 32'h088D52A2
//     MUL rs=5 rt=8 rd=4 -> 32'h08A822B2;  AND rs=10 rt=11 rd=9 -> 32'h094B4AA4
//     OR  rs=6 rt=1 rd=13 -> 32'h08C16AA5
//   3 out_ready=0, push 4 words -> in_ready=0 after the 4th.
//     Then pop 1 while in_valid stays high -> in_ready returns; exactly 5 words appear, in order.
//   4 in_op=7 with in_valid=1 -> accepted, err high for one cycle, FIFO occupancy unchanged, no output word.
//   5 3 words buffered, rst_n=0 for one edge -> out_valid=0, in_ready=1; subsequent words are encoded correctly.
//   6 ENC_STATS_EN defined: 5 pops plus 1 illegal op -> instr_count=5.
//     Preload the counter to 16'hFFFF, one pop -> instr_count=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the instruction encoder and the control decoder.
//   opE       - symbolic operation selector carried on in_op (0..7)
//   OPC_*     - 6-bit primary opcodes placed in word bits [31:26]
//   FUNCT_*   - 6-bit R-type function codes placed in word bits [5:0]
//   functFor  - maps an R-type opE to its function code
package mips_pkg;

  typedef enum logic [2:0] {
    OP_LW      = 3'd0,
    OP_SW      = 3'd1,
    OP_ADD     = 3'd2,
    OP_SUB     = 3'd3,
    OP_MUL     = 3'd4,
    OP_AND     = 3'd5,
    OP_OR      = 3'd6,
    OP_ILLEGAL = 3'd7
  } opE;

  localparam logic [5:0] OPC_R  = 6'd2;
  localparam logic [5:0] OPC_LW = 6'd3;
  localparam logic [5:0] OPC_SW = 6'd4;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_MUL = 6'h32;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;

  // Non-R-type ops have no function field; they return zero.
  function automatic logic [5:0] functFor(input opE op);
    logic [5:0] f;
    f = 6'h00;
    case (op)
      OP_ADD:  f = FUNCT_ADD;
      OP_SUB:  f = FUNCT_SUB;
      OP_MUL:  f = FUNCT_MUL;
      OP_AND:  f = FUNCT_AND;
      OP_OR:   f = FUNCT_OR;
      default: f = 6'h00;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO with valid/ready on both sides.
//   clk, rst_n         - clock, synchronous active-low reset (empties the FIFO)
//   wrValid/wrReady    - write handshake; wrReady = not full (depends on state only)
//   wrData [WIDTH]     - word written on a write handshake
//   rdValid/rdReady    - read handshake; rdValid = not empty
//   rdData [WIDTH]     - word at the head; zero while empty
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrValid,
  output logic             wrReady,
  input  logic [WIDTH-1:0] wrData,
  output logic             rdValid,
  input  logic             rdReady,
  output logic [WIDTH-1:0] rdData
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtrReg;
  logic [AW:0]      rdPtrReg;
  logic             fifoEmpty;
  logic             fifoFull;
  logic             doWrite;
  logic             doRead;

  assign fifoEmpty = (wrPtrReg == rdPtrReg);
  assign fifoFull  = (wrPtrReg[AW-1:0] == rdPtrReg[AW-1:0]) &&
                     (wrPtrReg[AW] != rdPtrReg[AW]);

  assign wrReady = !fifoFull;
  assign rdValid = !fifoEmpty;
  assign doWrite = wrValid && !fifoFull;
  assign doRead  = rdReady && !fifoEmpty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
    end else begin
      if (doWrite) wrPtrReg <= wrPtrReg + (AW+1)'(1);
      if (doRead)  rdPtrReg <= rdPtrReg + (AW+1)'(1);
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && doWrite) mem[wrPtrReg[AW-1:0]] <= wrData;
  end

  // Head is masked while empty so stale storage never shows on the output.
  assign rdData = fifoEmpty ? '0 : mem[rdPtrReg[AW-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic MIPS instructions into 32-bit words and buffers
// them in an output FIFO.
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid/in_ready     - input handshake; in_ready = FIFO not full
//   in_op [3]             - 0 LW, 1 SW, 2 ADD, 3 SUB, 4 MUL, 5 AND, 6 OR, 7 illegal
//   in_rs/in_rt/in_rd [5] - register numbers
//   in_imm [16]           - LW/SW offset
//   out_valid/out_ready   - output handshake
//   out_instr [32]        - encoded word at FIFO head
//   err                   - one-cycle pulse after an illegal op is accepted
//   instr_count [16]      - output handshake count (only with ENC_STATS_EN)
// Optional feature macro: ENC_STATS_EN adds the instr_count port and counter.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int SHAMT_R = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err
`ifdef ENC_STATS_EN
  ,
  output logic [15:0] instr_count
`endif
);

  opE          opSel;
  logic [31:0] encWord;
  logic        accept;
  logic        isIllegal;
  logic        fifoPush;
  logic        fifoReady;
  logic        errReg;

  assign opSel     = opE'(in_op);
  assign isIllegal = (opSel == OP_ILLEGAL);
  assign accept    = in_valid && fifoReady;
  // Illegal ops still complete the handshake but never reach the FIFO.
  assign fifoPush  = in_valid && !isIllegal;

  always_comb begin
    encWord = '0;
    case (opSel)
      OP_LW:   encWord = {OPC_LW, in_rs, in_rt, in_imm};
      OP_SW:   encWord = {OPC_SW, in_rs, in_rt, in_imm};
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR:
               encWord = {OPC_R, in_rs, in_rt, in_rd, 5'(SHAMT_R), functFor(opSel)};
      default: encWord = '0;
    endcase
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) uFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrValid (fifoPush),
    .wrReady (fifoReady),
    .wrData  (encWord),
    .rdValid (out_valid),
    .rdReady (out_ready),
    .rdData  (out_instr)
  );

  assign in_ready = fifoReady;

  always_ff @(posedge clk) begin
    if (!rst_n) errReg <= 1'b0;
    else        errReg <= accept && isIllegal;
  end

  assign err = errReg;

`ifdef ENC_STATS_EN
  logic [15:0] countReg;

  // Wraps naturally from 16'hFFFF to 0.
  always_ff @(posedge clk) begin
    if (!rst_n)                      countReg <= '0;
    else if (out_valid && out_ready) countReg <= countReg + 16'd1;
  end

  assign instr_count = countReg;
`endif

endmodule
